// File: rtl/lanectrl_tx_dly_tap_seq.sv
// TX delay-tap move/load sequencer for the LANECTRL delay line, FAB_CLK domain.
// Build macro LANECTRL_TX_DLY_CLK_PAUSE_EN wraps moves in HS_IO_CLK pause windows.
module lanectrl_tx_dly_tap_seq #(
  parameter int TAP_W       = 8,
  parameter int MAX_TAP     = 255,
  parameter int LOAD_TAP    = 1,
  parameter int PAUSE_SETUP = 2,
  parameter int PAUSE_HOLD  = 2,
  parameter int MOVE_GAP    = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_LOAD,
  input  logic             REQ_DIR,
  input  logic [TAP_W-1:0] REQ_TAPS,
  output logic             DONE,
  output logic             DONE_ERR,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

`ifdef LANECTRL_TX_DLY_CLK_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE_ON,
    S_MOVE,
    S_GAP,
    S_PAUSE_OFF,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TAP_W-1:0]   remain, remain_n;
  logic [TAP_W-1:0]   tap_q, tap_n, tap_step;
  logic               load_q, load_n;
  logic               dir_q, dir_n;
  logic               err_q, err_n;
  logic               busy_n;
  state_t             finish_state;

  function automatic logic at_limit(input logic d, input logic [TAP_W-1:0] t);
    return d ? (t == TAP_W'(MAX_TAP)) : (t == '0);
  endfunction

  assign TAP_COUNT    = tap_q;
  assign finish_state = PAUSE_EN ? S_PAUSE_OFF : S_DONE;

  // Next-state logic; outputs are registered from the next state so they line up with it
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    remain_n = remain;
    tap_n    = tap_q;
    load_n   = load_q;
    dir_n    = dir_q;
    err_n    = err_q;
    tap_step = '0;
    case (state)
      S_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          load_n   = REQ_LOAD;
          dir_n    = REQ_DIR;
          remain_n = REQ_TAPS;
          err_n    = 1'b0;
          cnt_n    = '0;
          if (!REQ_LOAD && REQ_TAPS == '0) begin
            state_n = S_DONE;
          end else if (PAUSE_EN) begin
            state_n = S_PAUSE_ON;
          end else if (!REQ_LOAD && at_limit(REQ_DIR, tap_q)) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            state_n = S_MOVE;
          end
        end
      end
      S_PAUSE_ON: begin
        if (cnt == CNT_W'(PAUSE_SETUP - 1)) begin
          cnt_n = '0;
          if (!load_q && at_limit(dir_q, tap_q)) begin
            state_n = S_PAUSE_OFF;
            err_n   = 1'b1;
          end else begin
            state_n = S_MOVE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_MOVE: begin
        state_n = S_GAP;
        cnt_n   = '0;
      end
      // The last gap cycle commits the tap change and decides whether another move follows
      S_GAP: begin
        if (cnt == CNT_W'(MOVE_GAP - 1)) begin
          cnt_n = '0;
          if (load_q) begin
            tap_n   = TAP_W'(LOAD_TAP);
            state_n = finish_state;
          end else if (TX_DELAY_LINE_OUT_OF_RANGE) begin
            err_n   = 1'b1;
            state_n = finish_state;
          end else begin
            tap_step = dir_q ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
            tap_n    = tap_step;
            remain_n = remain - TAP_W'(1);
            if (remain_n == '0) begin
              state_n = finish_state;
            end else if (at_limit(dir_q, tap_step)) begin
              err_n   = 1'b1;
              state_n = finish_state;
            end else begin
              state_n = S_MOVE;
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PAUSE_OFF: begin
        if (cnt == CNT_W'(PAUSE_HOLD - 1)) begin
          cnt_n   = '0;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy_n = (state_n == S_PAUSE_ON) || (state_n == S_MOVE) ||
                  (state_n == S_GAP) || (state_n == S_PAUSE_OFF);

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      remain               <= '0;
      tap_q                <= TAP_W'(LOAD_TAP);
      load_q               <= 1'b0;
      dir_q                <= 1'b0;
      err_q                <= 1'b0;
      REQ_READY            <= 1'b0;
      DONE                 <= 1'b0;
      DONE_ERR             <= 1'b0;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      HS_IO_CLK_PAUSE      <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      remain               <= remain_n;
      tap_q                <= tap_n;
      load_q               <= load_n;
      dir_q                <= dir_n;
      err_q                <= err_n;
      REQ_READY            <= (state_n == S_IDLE);
      DONE                 <= (state_n == S_DONE);
      DONE_ERR             <= (state_n == S_DONE) && err_n;
      DELAY_LINE_SEL       <= busy_n;
      DELAY_LINE_DIRECTION <= busy_n && dir_n;
      DELAY_LINE_MOVE      <= (state_n == S_MOVE) && !load_n;
      DELAY_LINE_LOAD      <= (state_n == S_MOVE) && load_n;
      HS_IO_CLK_PAUSE      <= PAUSE_EN && busy_n;
    end
  end

endmodule

// File: tb/tb_lanectrl_tx_dly_tap_seq.sv
// Directed bench for lanectrl_tx_dly_tap_seq; cycle k is sampled #1 after the (k-1)th edge
// following the acceptance edge. Honours LANECTRL_TX_DLY_CLK_PAUSE_EN when set.
module tb_lanectrl_tx_dly_tap_seq;

`ifdef LANECTRL_TX_DLY_CLK_PAUSE_EN
  localparam int PS  = 2;
  localparam int PH  = 2;
  localparam bit PEN = 1'b1;
`else
  localparam int PS  = 0;
  localparam int PH  = 0;
  localparam bit PEN = 1'b0;
`endif
  localparam int G = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_load = 1'b0;
  logic       req_dir = 1'b0;
  logic [7:0] req_taps = 8'd0;
  logic       oor = 1'b0;
  logic       req_ready, done, done_err, dl_sel, dl_load, dl_dir, dl_move, pause;
  logic [7:0] tap_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lanectrl_tx_dly_tap_seq dut (
    .FAB_CLK                    (clk),
    .RESET_N                    (rst_n),
    .REQ_VALID                  (req_valid),
    .REQ_READY                  (req_ready),
    .REQ_LOAD                   (req_load),
    .REQ_DIR                    (req_dir),
    .REQ_TAPS                   (req_taps),
    .DONE                       (done),
    .DONE_ERR                   (done_err),
    .TAP_COUNT                  (tap_count),
    .DELAY_LINE_SEL             (dl_sel),
    .DELAY_LINE_LOAD            (dl_load),
    .DELAY_LINE_DIRECTION       (dl_dir),
    .DELAY_LINE_MOVE            (dl_move),
    .HS_IO_CLK_PAUSE            (pause),
    .TX_DELAY_LINE_OUT_OF_RANGE (oor)
  );

  // Expected {move, load, pause, sel, dir, done, ready} at cycle k of a request
  function automatic logic [6:0] exp_vec(input int k, input int n, input int dcyc,
                                         input bit ld, input bit dr);
    logic pulse, busy;
    pulse = (k >= PS + 1) && (k <= PS + n * G) && (((k - PS - 1) % G) == 0);
    busy  = (k >= 1) && (k < dcyc);
    return {pulse && !ld, pulse && ld, PEN && busy, busy, busy && dr, k == dcyc, k > dcyc};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {dl_move, dl_load, pause, dl_sel, dl_dir, done, req_ready};
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    oor       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for READY, presents the request and returns at the cycle-1 sample point
  task automatic start_req(input logic ld, input logic dr, input logic [7:0] taps,
                           input bit hold);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 50) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL start_timeout ready=%b required=1", req_ready);
    end
    req_load  = ld;
    req_dir   = dr;
    req_taps  = taps;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({obs_vec(), done_err, tap_count} !== {7'b0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL reset_values got=%b/%b/%0d required=0000000/0/1",
               obs_vec(), done_err, tap_count);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready got=%b required=1", req_ready);
    end
  endtask

  task automatic test_move_up();
    int dcyc;
    apply_reset();
    dcyc = 1 + PS + 3 * G + PH;
    start_req(1'b0, 1'b1, 8'd3, 1'b0);
    for (int k = 1; k <= dcyc + 1; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k, 3, dcyc, 1'b0, 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL move_up_c%0d got=%b required=%b", k, obs_vec(),
                 exp_vec(k, 3, dcyc, 1'b0, 1'b1));
      end
      if (k == dcyc) begin
        n_checks++;
        if (done_err !== 1'b0 || tap_count !== 8'd4) begin
          n_fail++;
          $display("[TB] FAIL move_up_result err=%b tap=%0d required err=0 tap=4",
                   done_err, tap_count);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturation();
    int dcyc;
    apply_reset();
    dcyc = 1 + PS + G + PH;
    start_req(1'b0, 1'b0, 8'd5, 1'b0);
    for (int k = 1; k <= dcyc + 1; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k, 1, dcyc, 1'b0, 1'b0)) begin
        n_fail++;
        $display("[TB] FAIL sat_down_c%0d got=%b required=%b", k, obs_vec(),
                 exp_vec(k, 1, dcyc, 1'b0, 1'b0));
      end
      if (k == dcyc) begin
        n_checks++;
        if (done_err !== 1'b1 || tap_count !== 8'd0) begin
          n_fail++;
          $display("[TB] FAIL sat_down_result err=%b tap=%0d required err=1 tap=0",
                   done_err, tap_count);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_out_of_range();
    int dcyc;
    apply_reset();
    dcyc = 1 + PS + 2 * G + PH;
    start_req(1'b0, 1'b1, 8'd4, 1'b0);
    for (int k = 1; k <= dcyc + 1; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k, 2, dcyc, 1'b0, 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL oor_c%0d got=%b required=%b", k, obs_vec(),
                 exp_vec(k, 2, dcyc, 1'b0, 1'b1));
      end
      if (k == dcyc) begin
        n_checks++;
        if (done_err !== 1'b1 || tap_count !== 8'd2) begin
          n_fail++;
          $display("[TB] FAIL oor_result err=%b tap=%0d required err=1 tap=2",
                   done_err, tap_count);
        end
      end
      if (k == PS + 7) oor = 1'b1;
      if (k == PS + 11) oor = 1'b0;
      @(posedge clk);
      #1;
    end
    oor = 1'b0;
  endtask

  task automatic test_load();
    int dcyc;
    int w;
    apply_reset();
    start_req(1'b0, 1'b1, 8'd39, 1'b0);
    w = 0;
    while (done !== 1'b1 && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_checks++;
    if (done !== 1'b1 || done_err !== 1'b0 || tap_count !== 8'd40) begin
      n_fail++;
      $display("[TB] FAIL load_preset done=%b err=%b tap=%0d required done=1 err=0 tap=40",
               done, done_err, tap_count);
    end
    dcyc = 1 + PS + G + PH;
    start_req(1'b1, 1'b1, 8'd0, 1'b0);
    for (int k = 1; k <= dcyc + 1; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k, 1, dcyc, 1'b1, 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL load_c%0d got=%b required=%b", k, obs_vec(),
                 exp_vec(k, 1, dcyc, 1'b1, 1'b1));
      end
      if (k == 1) begin
        n_checks++;
        if (tap_count !== 8'd40) begin
          n_fail++;
          $display("[TB] FAIL load_tap_before got=%0d required=40", tap_count);
        end
      end
      if (k == dcyc) begin
        n_checks++;
        if (done_err !== 1'b0 || tap_count !== 8'd1) begin
          n_fail++;
          $display("[TB] FAIL load_result err=%b tap=%0d required err=0 tap=1",
                   done_err, tap_count);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_move();
    apply_reset();
    start_req(1'b0, 1'b1, 8'd3, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (pause !== PEN || dl_sel !== 1'b1 || tap_count !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL mid_move_c9 pause=%b sel=%b tap=%0d required pause=%b sel=1 tap=2",
               pause, dl_sel, tap_count, PEN);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({pause, dl_sel, dl_move, done, req_ready, tap_count} !== {5'b0, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL mid_move_reset pause/sel/move/done/ready=%b%b%b%b%b tap=%0d required 00000 tap=1",
               pause, dl_sel, dl_move, done, req_ready, tap_count);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_move_release ready=%b done=%b required ready=1 done=0",
               req_ready, done);
    end
  endtask

  task automatic test_back_to_back();
    int dcyc;
    apply_reset();
    start_req(1'b0, 1'b1, 8'd0, 1'b1);
    n_checks++;
    if ({done, done_err, pause, dl_sel, req_ready} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL zero_taps_c1 done/err/pause/sel/ready=%b%b%b%b%b required 10000",
               done, done_err, pause, dl_sel, req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, req_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL zero_taps_c2 done/ready=%b%b required 01", done, req_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, done_err, req_ready} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL zero_taps_c3 done/err/ready=%b%b%b required 100",
               done, done_err, req_ready);
    end
    req_taps = 8'd1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, req_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL zero_taps_c4 done/ready=%b%b required 01", done, req_ready);
    end
    // The held request is taken on this edge; later field changes must not leak in
    @(posedge clk);
    #1;
    req_dir  = 1'b0;
    req_taps = 8'd9;
    dcyc = 1 + PS + G + PH;
    for (int k = 1; k <= dcyc + 2; k++) begin
      n_checks++;
      if (obs_vec() !== exp_vec(k, 1, dcyc, 1'b0, 1'b1)) begin
        n_fail++;
        $display("[TB] FAIL busy_valid_c%0d got=%b required=%b", k, obs_vec(),
                 exp_vec(k, 1, dcyc, 1'b0, 1'b1));
      end
      if (k == dcyc) begin
        n_checks++;
        if (done_err !== 1'b0 || tap_count !== 8'd2) begin
          n_fail++;
          $display("[TB] FAIL busy_valid_result err=%b tap=%0d required err=0 tap=2",
                   done_err, tap_count);
        end
        req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_move_up();
    test_saturation();
    test_out_of_range();
    test_load();
    test_reset_mid_move();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/lanectrl_tx_dly_tap_seq.md
# lanectrl_tx_dly_tap_seq

Fabric-side sequencer that drives the delay-line control inputs of the DDR4 address/command lane controller. It accepts tap-move or load requests from the training logic, surrounds every move with an HS_IO_CLK pause window, and issues single-cycle move pulses with enforced spacing. It tracks the current TX delay tap and aborts on the lane controller's out-of-range flag. It sits between the PHY training FSM and the LANECTRL delay-line/pause pins, all in the FAB_CLK domain.

## Interface
Parameters:
- TAP_W, 8, tap count / request width
- MAX_TAP, 255, highest legal tap
- LOAD_TAP, 1, tap value after reset or LOAD (matches TX delay init value)
- PAUSE_SETUP, 2, cycles HS_IO_CLK_PAUSE is high before the first move (>=1)
- PAUSE_HOLD, 2, cycles HS_IO_CLK_PAUSE stays high after the last gap (>=1)
- MOVE_GAP, 4, idle cycles after each move pulse (>=1)

Ports:
- FAB_CLK  in  1  sole clock
- RESET_N  in  1  synchronous, active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block idle, request accepted on VALID&&READY
- REQ_LOAD  in  1  1 = load (restore LOAD_TAP), 0 = move
- REQ_DIR  in  1  move direction, 1 = increment
- REQ_TAPS  in  TAP_W  number of taps to move
- DONE  out  1  one-cycle completion pulse
- DONE_ERR  out  1  valid with DONE; 1 = aborted
- TAP_COUNT  out  TAP_W  current tracked tap
- DELAY_LINE_SEL  out  1  selects TX delay line
- DELAY_LINE_LOAD  out  1  load pulse
- DELAY_LINE_DIRECTION  out  1  registered copy of REQ_DIR
- DELAY_LINE_MOVE  out  1  move pulse
- HS_IO_CLK_PAUSE  out  1  high-speed clock pause
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  from lane controller

## Operation
- All outputs are registered. Reset values: REQ_READY=0, DONE=0, DONE_ERR=0, DELAY_LINE_*=0, HS_IO_CLK_PAUSE=0, TAP_COUNT=LOAD_TAP, state=IDLE.
- States: IDLE -> PAUSE_ON (PAUSE_SETUP cycles) -> MOVE (1 cycle) -> GAP (MOVE_GAP cycles) -> MOVE while taps remain -> PAUSE_OFF (PAUSE_HOLD cycles) -> DONE (1 cycle) -> IDLE.
- LOAD request: same path, except MOVE drives DELAY_LINE_LOAD instead of DELAY_LINE_MOVE. There is exactly one LOAD pulse. TAP_COUNT becomes LOAD_TAP at the end of GAP.
- REQ_READY=1 only in IDLE. Request fields are captured on acceptance.
- DELAY_LINE_SEL and DELAY_LINE_DIRECTION are held from PAUSE_ON entry through PAUSE_OFF end, then return to 0.
- HS_IO_CLK_PAUSE is high in PAUSE_ON, MOVE, GAP and PAUSE_OFF.
- TAP_COUNT is incremented or decremented by 1 on the last GAP cycle, only if TX_DELAY_LINE_OUT_OF_RANGE is low on that cycle.
- Out-of-range sampled high on the last GAP cycle: remaining moves are cancelled, go to PAUSE_OFF, DONE_ERR=1.
- Saturation is checked before each MOVE. If REQ_DIR=1 with TAP_COUNT==MAX_TAP, or REQ_DIR=0 with TAP_COUNT==0, no pulse is issued; go to PAUSE_OFF with DONE_ERR=1.
- Move with REQ_TAPS=0: IDLE -> DONE directly, no pause, DONE_ERR=0.
- REQ_VALID while busy is ignored.
- RESET_N low in any state forces reset values on the next edge, including mid-pause. HS_IO_CLK_PAUSE drops immediately.

## Timing
- Acceptance edge is cycle 0.
- Defaults, N=3 move: PAUSE high cycles 1–19; MOVE pulses at 3, 8, 13; GAPs 4–7, 9–12, 14–17; PAUSE_OFF 18–19; DONE at 20; REQ_READY=1 at 21.
- General DONE cycle: 1 + PAUSE_SETUP + N*(1+MOVE_GAP) + PAUSE_HOLD.
- N=0: DONE at cycle 1.
- After reset release, REQ_READY=1 on the first edge with RESET_N high.

## Configuration
- Macro: LANECTRL_TX_DLY_CLK_PAUSE_EN.
- Defined: pause windows as above.
- Undefined: PAUSE_ON and PAUSE_OFF take zero cycles and HS_IO_CLK_PAUSE is constant 0. Defaults, N=3: MOVE pulses at 1, 6, 11; DONE at 16.

## Test plan
- Reset, then move REQ_DIR=1, REQ_TAPS=3 -> MOVE pulses at cycles 3/8/13, PAUSE high 1–19, DONE at 20 with DONE_ERR=0, TAP_COUNT=4.
- Move REQ_DIR=0, REQ_TAPS=5 from TAP_COUNT=1 -> one pulse, then saturation abort; TAP_COUNT=0, DONE_ERR=1, DONE at cycle 1+2+5+2=10.
- Force TX_DELAY_LINE_OUT_OF_RANGE=1 during the second GAP of a 4-tap increment from 1 -> 2 pulses, TAP_COUNT=2, DONE_ERR=1.
- LOAD request from TAP_COUNT=40 -> single DELAY_LINE_LOAD pulse at cycle 3, no MOVE pulse, TAP_COUNT=1, DONE at 10.
- RESET_N low at cycle 9 of a 3-tap move -> next edge: PAUSE=0, SEL=0, TAP_COUNT=1, no DONE; REQ_READY=1 on the first edge after release.
- REQ_TAPS=0, plus REQ_VALID held high while busy -> DONE at cycle 1, no pause; a second request is accepted only when REQ_READY=1.
